// File: rtl/rcpu_bus_slave_pkg.sv
// rtl/rcpu_bus_slave_pkg.sv - memory map constants, STATUS bit positions and address decode for rcpu_bus_slave
//
// Purpose: single source of the RCPU memory map. The address constants and
// STATUS bit positions are shared with rcpu software tests, so any change
// here must be mirrored there.

package rcpu_bus_slave_pkg;

    // Memory map
    localparam logic [15:0] RAM_TOP     = 16'hF000;
    localparam logic [15:0] ADDR_OUT    = 16'hF000;
    localparam logic [15:0] ADDR_IN     = 16'hF001;
    localparam logic [15:0] ADDR_TXDATA = 16'hF002;
    localparam logic [15:0] ADDR_STATUS = 16'hF003;
    localparam logic [15:0] ADDR_TIMER  = 16'hF004;

    // STATUS register layout
    localparam int STAT_FULL      = 0;
    localparam int STAT_EMPTY     = 1;
    localparam int STAT_EXPIRED   = 2;
    localparam int STAT_OVERFLOW  = 3;
    localparam int STAT_COUNT_LSB = 8;

    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_RAM,
        SEL_OUT,
        SEL_IN,
        SEL_TXDATA,
        SEL_STATUS,
        SEL_TIMER
    } sel_e;

    // Unmapped MMIO addresses fall through to SEL_NONE: reads 0, writes dropped.
    function automatic sel_e decode_addr(input logic [15:0] addr);
        sel_e sel;
        sel = SEL_NONE;
        if (addr < RAM_TOP) begin
            sel = SEL_RAM;
        end else begin
            case (addr)
                ADDR_OUT:    sel = SEL_OUT;
                ADDR_IN:     sel = SEL_IN;
                ADDR_TXDATA: sel = SEL_TXDATA;
                ADDR_STATUS: sel = SEL_STATUS;
                ADDR_TIMER:  sel = SEL_TIMER;
                default:     sel = SEL_NONE;
            endcase
        end
        return sel;
    endfunction

endpackage

// File: rtl/tx_fifo.sv
// rtl/tx_fifo.sv - byte TX FIFO with valid/ready drain side and sticky overflow flag
//
// Ports:
//   i_clk, i_rst_n        clock, asynchronous active-low reset
//   i_push, i_data        push request and byte
//   i_ready               consumer ready; pop happens on o_valid && i_ready
//   o_data, o_valid       head byte (0 when empty), non-empty
//   o_full, o_empty       occupancy flags
//   o_count               number of stored entries
//   o_overflow, i_ovf_clr sticky dropped-push flag and its clear

module tx_fifo #(
    parameter  int FIFO_DEPTH = 4,
    parameter  int WIDTH      = 8,
    localparam int AW         = $clog2(FIFO_DEPTH),
    localparam int CW         = $clog2(FIFO_DEPTH) + 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_data,
    output logic             o_valid,
    output logic             o_full,
    output logic             o_empty,
    output logic [CW-1:0]    o_count,
    output logic             o_overflow,
    input  logic             i_ovf_clr
);

    logic [WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             r_overflow;

    logic w_empty;
    logic w_full;
    logic w_pop;
    logic w_push;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == CW'(FIFO_DEPTH));
    assign w_pop   = !w_empty && i_ready;
    // A push into a full FIFO is still taken when the head leaves on the same
    // edge: the write lands in the slot being vacated.
    assign w_push  = i_push && (!w_full || w_pop);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            // A new drop wins over a same-cycle clear so no event is lost.
            r_overflow <= (i_push && w_full && !w_pop) || (r_overflow && !i_ovf_clr);
        end
    end

    // Storage is not reset; the empty flag masks stale contents.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    assign o_data     = w_empty ? '0 : r_mem[r_rd_ptr];
    assign o_valid    = !w_empty;
    assign o_full     = w_full;
    assign o_empty    = w_empty;
    assign o_count    = r_count;
    assign o_overflow = r_overflow;

endmodule

// File: rtl/rcpu_bus_slave.sv
// rtl/rcpu_bus_slave.sv - RCPU memory-port responder: word RAM plus GPIO, TX FIFO and timer MMIO page
//
// Ports:
//   clk, rst              clock, asynchronous active-low reset
//   memAddr, memWrite     CPU address and store data
//   memRE, memWE          read / write enables
//   memRead               combinational read data (0 when memRE is low)
//   gpio_out, gpio_in     output register, asynchronous input pins
//   tx_data, tx_valid     TX FIFO head byte and non-empty
//   tx_ready              consumer accept
//   irq_timer             sticky timer-expired flag

module rcpu_bus_slave
    import rcpu_bus_slave_pkg::*;
#(
    parameter int M          = 16,
    parameter int RAM_AW     = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int TICK_DIV   = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [M-1:0] memAddr,
    input  logic [M-1:0] memWrite,
    input  logic         memRE,
    input  logic         memWE,
    output logic [M-1:0] memRead,
    output logic [15:0]  gpio_out,
    input  logic [15:0]  gpio_in,
    output logic [7:0]   tx_data,
    output logic         tx_valid,
    input  logic         tx_ready,
    output logic         irq_timer
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [M-1:0]  r_ram [2**RAM_AW];
    logic [15:0]   r_gpio_out;
    logic [15:0]   r_sync1;
    logic [15:0]   r_sync2;
    logic [15:0]   r_timer;
    logic [PW-1:0] r_presc;
    logic          r_expired;

    sel_e          w_sel;
    logic [RAM_AW-1:0] w_ram_idx;
    logic          w_wr_ram;
    logic          w_wr_out;
    logic          w_wr_tx;
    logic          w_wr_status;
    logic          w_wr_timer;
    logic          w_tick;
    logic          w_expire_evt;
    logic          w_clr_expired;
    logic          w_clr_ovf;
    logic [15:0]   w_status;
    logic [M-1:0]  w_rdata;

    logic          w_fifo_full;
    logic          w_fifo_empty;
    logic          w_fifo_ovf;
    logic [CW-1:0] w_fifo_count;

    assign w_sel       = decode_addr(memAddr[15:0]);
    assign w_ram_idx   = memAddr[RAM_AW-1:0];
    assign w_wr_ram    = memWE && (w_sel == SEL_RAM);
    assign w_wr_out    = memWE && (w_sel == SEL_OUT);
    assign w_wr_tx     = memWE && (w_sel == SEL_TXDATA);
    assign w_wr_status = memWE && (w_sel == SEL_STATUS);
    assign w_wr_timer  = memWE && (w_sel == SEL_TIMER);

    assign w_clr_ovf     = w_wr_status && memWrite[STAT_OVERFLOW];
    assign w_clr_expired = w_wr_status && memWrite[STAT_EXPIRED];

    // Prescaler wrap; a CPU load restarts the prescaler and masks the tick.
    assign w_tick       = (r_presc == PW'(TICK_DIV - 1));
    assign w_expire_evt = w_tick && !w_wr_timer && (r_timer == 16'd1);

    // RAM: asynchronous read, synchronous write, deliberately not reset so
    // contents survive a CPU reset.
    always_ff @(posedge clk) begin
        if (w_wr_ram) begin
            r_ram[w_ram_idx] <= memWrite;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_gpio_out <= '0;
            r_sync1    <= '0;
            r_sync2    <= '0;
            r_timer    <= '0;
            r_presc    <= '0;
            r_expired  <= 1'b0;
        end else begin
            r_sync1 <= gpio_in;
            r_sync2 <= r_sync1;
            if (w_wr_out) begin
                r_gpio_out <= memWrite[15:0];
            end
            if (w_wr_timer) begin
                r_timer <= memWrite[15:0];
                r_presc <= '0;
            end else begin
                r_presc <= w_tick ? '0 : r_presc + PW'(1);
                if (w_tick && (r_timer != 16'd0)) begin
                    r_timer <= r_timer - 16'd1;
                end
            end
            // Expiry wins over a same-cycle W1C so the event is never lost.
            r_expired <= w_expire_evt || (r_expired && !w_clr_expired);
        end
    end

    tx_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .WIDTH      (8)
    ) u_tx_fifo (
        .i_clk      (clk),
        .i_rst_n    (rst),
        .i_push     (w_wr_tx),
        .i_data     (memWrite[7:0]),
        .i_ready    (tx_ready),
        .o_data     (tx_data),
        .o_valid    (tx_valid),
        .o_full     (w_fifo_full),
        .o_empty    (w_fifo_empty),
        .o_count    (w_fifo_count),
        .o_overflow (w_fifo_ovf),
        .i_ovf_clr  (w_clr_ovf)
    );

    always_comb begin
        w_status                                 = '0;
        w_status[STAT_COUNT_LSB +: 8]            = 8'(w_fifo_count);
        w_status[STAT_OVERFLOW]                  = w_fifo_ovf;
        w_status[STAT_EXPIRED]                   = r_expired;
        w_status[STAT_EMPTY]                     = w_fifo_empty;
        w_status[STAT_FULL]                      = w_fifo_full;
    end

    // Reads are side-effect free; TXDATA reads back 0.
    always_comb begin
        w_rdata = '0;
        if (memRE) begin
            case (w_sel)
                SEL_RAM:    w_rdata = r_ram[w_ram_idx];
                SEL_OUT:    w_rdata = M'(r_gpio_out);
                SEL_IN:     w_rdata = M'(r_sync2);
                SEL_STATUS: w_rdata = M'(w_status);
                SEL_TIMER:  w_rdata = M'(r_timer);
                default:    w_rdata = '0;
            endcase
        end
    end

    assign memRead   = w_rdata;
    assign gpio_out  = r_gpio_out;
    assign irq_timer = r_expired;

endmodule

// File: tb/tb_rcpu_bus_slave.sv
// tb/tb_rcpu_bus_slave.sv - self-checking bench for rcpu_bus_slave with a TX byte scoreboard

module tb_rcpu_bus_slave;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] memAddr;
    logic [15:0] memWrite;
    logic        memRE;
    logic        memWE;
    logic [15:0] memRead;
    logic [15:0] gpio_out;
    logic [15:0] gpio_in;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        irq_timer;

    int tests = 0;
    int fails = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    rcpu_bus_slave #(
        .M(16), .RAM_AW(16), .FIFO_DEPTH(4), .TICK_DIV(16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .memAddr   (memAddr),
        .memWrite  (memWrite),
        .memRE     (memRE),
        .memWE     (memWE),
        .memRead   (memRead),
        .gpio_out  (gpio_out),
        .gpio_in   (gpio_in),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .irq_timer (irq_timer)
    );

    task automatic bus_write(input logic [15:0] a, input logic [15:0] d);
        @(negedge clk);
        memAddr  = a;
        memWrite = d;
        memRE    = 1'b0;
        memWE    = 1'b1;
        @(negedge clk);
        memWE    = 1'b0;
    endtask

    task automatic bus_read(input logic [15:0] a, output logic [15:0] d);
        memAddr = a;
        memRE   = 1'b1;
        #1;
        d       = memRead;
        memRE   = 1'b0;
    endtask

    task automatic test_reset();
        logic [15:0] rd;
        rst = 1'b0; memAddr = '0; memWrite = '0; memRE = 1'b0; memWE = 1'b0;
        gpio_in = '0; tx_ready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        tests++; if (gpio_out !== 16'h0) begin fails++; $display("FAIL reset_gpio_out: got %h exp 0000", gpio_out); end
        tests++; if (tx_valid !== 1'b0) begin fails++; $display("FAIL reset_tx_valid: got %b exp 0", tx_valid); end
        tests++; if (tx_data !== 8'h0) begin fails++; $display("FAIL reset_tx_data: got %h exp 00", tx_data); end
        tests++; if (irq_timer !== 1'b0) begin fails++; $display("FAIL reset_irq: got %b exp 0", irq_timer); end
        tests++; if (memRead !== 16'h0) begin fails++; $display("FAIL reset_rd_idle: got %h exp 0000", memRead); end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        bus_read(16'hF003, rd);
        tests++; if (rd !== 16'h0002) begin fails++; $display("FAIL reset_status: got %h exp 0002", rd); end
        bus_read(16'hF004, rd);
        tests++; if (rd !== 16'h0000) begin fails++; $display("FAIL reset_timer: got %h exp 0000", rd); end
    endtask

    task automatic test_ram();
        logic [15:0] rd;
        bus_write(16'h0100, 16'h1234);
        bus_read(16'h0100, rd);
        tests++; if (rd !== 16'h1234) begin fails++; $display("FAIL ram_rw: got %h exp 1234", rd); end
        bus_write(16'hEFFF, 16'h5A5A);
        bus_read(16'hEFFF, rd);
        tests++; if (rd !== 16'h5A5A) begin fails++; $display("FAIL ram_top: got %h exp 5a5a", rd); end
        bus_read(16'hF0FF, rd);
        tests++; if (rd !== 16'h0) begin fails++; $display("FAIL unmapped_f0ff: got %h exp 0000", rd); end
        bus_read(16'hF1A0, rd);
        tests++; if (rd !== 16'h0) begin fails++; $display("FAIL unmapped_f1a0: got %h exp 0000", rd); end
        bus_read(16'hF002, rd);
        tests++; if (rd !== 16'h0) begin fails++; $display("FAIL txdata_read: got %h exp 0000", rd); end
        bus_write(16'hF0FF, 16'hFFFF);
        bus_write(16'hF1A0, 16'hFFFF);
        #1;
        tests++; if (gpio_out !== 16'h0) begin fails++; $display("FAIL unmapped_wr_gpio: got %h exp 0000", gpio_out); end
        tests++; if (tx_valid !== 1'b0) begin fails++; $display("FAIL unmapped_wr_fifo: got %b exp 0", tx_valid); end
        bus_read(16'hF003, rd);
        tests++; if (rd !== 16'h0002) begin fails++; $display("FAIL unmapped_wr_status: got %h exp 0002", rd); end
        bus_read(16'hF004, rd);
        tests++; if (rd !== 16'h0000) begin fails++; $display("FAIL unmapped_wr_timer: got %h exp 0000", rd); end
        memAddr = 16'h0100; memRE = 1'b0; #1;
        tests++; if (memRead !== 16'h0) begin fails++; $display("FAIL re_low: got %h exp 0000", memRead); end
        @(negedge clk);
        memAddr = 16'h0100; memWrite = 16'h9999; memWE = 1'b1; memRE = 1'b1;
        #1;
        tests++; if (memRead !== 16'h1234) begin fails++; $display("FAIL re_we_pre: got %h exp 1234", memRead); end
        @(negedge clk);
        memWE = 1'b0;
        #1;
        tests++; if (memRead !== 16'h9999) begin fails++; $display("FAIL re_we_post: got %h exp 9999", memRead); end
        memRE = 1'b0;
    endtask

    task automatic test_gpio();
        logic [15:0] rd;
        bus_write(16'hF000, 16'h00A5);
        #1;
        tests++; if (gpio_out !== 16'h00A5) begin fails++; $display("FAIL gpio_out: got %h exp 00a5", gpio_out); end
        bus_read(16'hF000, rd);
        tests++; if (rd !== 16'h00A5) begin fails++; $display("FAIL gpio_out_rd: got %h exp 00a5", rd); end
        @(negedge clk);
        gpio_in = 16'hBEEF;
        bus_read(16'hF001, rd);
        tests++; if (rd !== 16'h0000) begin fails++; $display("FAIL gpio_in_c1: got %h exp 0000", rd); end
        @(negedge clk);
        bus_read(16'hF001, rd);
        tests++; if (rd !== 16'h0000) begin fails++; $display("FAIL gpio_in_c2: got %h exp 0000", rd); end
        @(negedge clk);
        bus_read(16'hF001, rd);
        tests++; if (rd !== 16'hBEEF) begin fails++; $display("FAIL gpio_in_c3: got %h exp beef", rd); end
    endtask

    task automatic test_fifo();
        logic [15:0] rd;
        logic [15:0] exp_status;
        int          mcount;
        logic        movf;
        logic [7:0]  b;
        mcount = 0; movf = 1'b0;
        tx_ready = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            b = 8'(i * 8'h11);
            bus_write(16'hF002, {8'hEE, b});
            if (mcount < 4) begin
                exp_q.push_back(b);
                mcount++;
            end else begin
                movf = 1'b1;
            end
            #1;
            tests++; if (tx_valid !== 1'b1 || tx_data !== 8'h11) begin fails++; $display("FAIL fifo_head_%0d: got v=%b d=%h exp v=1 d=11", i, tx_valid, tx_data); end
        end
        exp_status = {8'(mcount), 4'b0, movf, 1'b0, (mcount == 0), (mcount == 4)};
        bus_read(16'hF003, rd);
        tests++; if (rd !== exp_status) begin fails++; $display("FAIL fifo_status_full: got %h exp %h", rd, exp_status); end
        tx_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            if (exp_q.size() == 0) break;
            tests++; if (tx_valid !== 1'b1 || tx_data !== exp_q[0]) begin fails++; $display("FAIL fifo_pop_%0d: got v=%b d=%h exp v=1 d=%h", i, tx_valid, tx_data, exp_q[0]); end
            void'(exp_q.pop_front());
            @(negedge clk);
        end
        tests++; if (tx_valid !== 1'b0 || tx_data !== 8'h0) begin fails++; $display("FAIL fifo_drained: got v=%b d=%h exp v=0 d=00", tx_valid, tx_data); end
        tx_ready = 1'b0;
        bus_read(16'hF003, rd);
        tests++; if (rd !== 16'h0008 + 16'h0002) begin fails++; $display("FAIL fifo_ovf_sticky: got %h exp 000a", rd); end
        bus_write(16'hF003, 16'h0008);
        bus_read(16'hF003, rd);
        tests++; if (rd !== 16'h0002) begin fails++; $display("FAIL fifo_ovf_w1c: got %h exp 0002", rd); end
    endtask

    task automatic test_fifo_full_pop();
        logic [15:0] rd;
        logic [7:0]  b;
        tx_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            b = 8'hA1 + 8'(i);
            bus_write(16'hF002, {8'h00, b});
            exp_q.push_back(b);
        end
        @(negedge clk);
        memAddr = 16'hF002; memWrite = 16'h0066; memWE = 1'b1; tx_ready = 1'b1;
        #1;
        tests++; if (tx_data !== exp_q[0]) begin fails++; $display("FAIL fullpop_head: got %h exp %h", tx_data, exp_q[0]); end
        void'(exp_q.pop_front());
        exp_q.push_back(8'h66);
        @(negedge clk);
        memWE = 1'b0; tx_ready = 1'b0;
        bus_read(16'hF003, rd);
        tests++; if (rd !== 16'h0401) begin fails++; $display("FAIL fullpop_status: got %h exp 0401", rd); end
        tx_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            if (exp_q.size() == 0) break;
            tests++; if (tx_valid !== 1'b1 || tx_data !== exp_q[0]) begin fails++; $display("FAIL fullpop_pop_%0d: got v=%b d=%h exp v=1 d=%h", i, tx_valid, tx_data, exp_q[0]); end
            void'(exp_q.pop_front());
            @(negedge clk);
        end
        tests++; if (tx_valid !== 1'b0) begin fails++; $display("FAIL fullpop_drained: got %b exp 0", tx_valid); end
        tx_ready = 1'b0;
    endtask

    task automatic test_timer();
        logic [15:0] rd;
        bus_write(16'hF004, 16'd3);
        for (int k = 1; k <= 48; k++) begin
            @(negedge clk);
            if (k == 15) begin
                bus_read(16'hF004, rd);
                tests++; if (rd !== 16'd3) begin fails++; $display("FAIL timer_k15: got %h exp 0003", rd); end
            end
            if (k == 16) begin
                bus_read(16'hF004, rd);
                tests++; if (rd !== 16'd2) begin fails++; $display("FAIL timer_k16: got %h exp 0002", rd); end
            end
            if (k == 47) begin
                #1;
                tests++; if (irq_timer !== 1'b0) begin fails++; $display("FAIL timer_early: got %b exp 0", irq_timer); end
            end
        end
        #1;
        tests++; if (irq_timer !== 1'b1) begin fails++; $display("FAIL timer_expire48: got %b exp 1", irq_timer); end
        bus_read(16'hF003, rd);
        tests++; if (rd !== 16'h0006) begin fails++; $display("FAIL timer_status: got %h exp 0006", rd); end
        repeat (20) @(negedge clk);
        bus_read(16'hF004, rd);
        tests++; if (rd !== 16'd0 || irq_timer !== 1'b1) begin fails++; $display("FAIL timer_hold: got cnt=%h irq=%b exp cnt=0000 irq=1", rd, irq_timer); end
        bus_write(16'hF003, 16'h0004);
        #1;
        tests++; if (irq_timer !== 1'b0) begin fails++; $display("FAIL timer_w1c: got %b exp 0", irq_timer); end
        bus_write(16'hF004, 16'd0);
        repeat (40) @(negedge clk);
        bus_read(16'hF003, rd);
        tests++; if (rd !== 16'h0002 || irq_timer !== 1'b0) begin fails++; $display("FAIL timer_load0: got st=%h irq=%b exp st=0002 irq=0", rd, irq_timer); end
    endtask

    task automatic test_async_reset();
        logic [15:0] rd;
        bus_write(16'h0300, 16'hCAFE);
        bus_write(16'hF000, 16'h5A5A);
        tx_ready = 1'b0;
        bus_write(16'hF002, 16'h0077);
        bus_write(16'hF002, 16'h0088);
        bus_write(16'hF004, 16'd100);
        bus_read(16'hF004, rd);
        tests++; if (rd !== 16'd100 || tx_valid !== 1'b1) begin fails++; $display("FAIL arst_setup: got cnt=%h v=%b exp cnt=0064 v=1", rd, tx_valid); end
        #1;
        rst = 1'b0;
        #1;
        tests++; if (tx_valid !== 1'b0 || tx_data !== 8'h0) begin fails++; $display("FAIL arst_fifo: got v=%b d=%h exp v=0 d=00", tx_valid, tx_data); end
        tests++; if (gpio_out !== 16'h0) begin fails++; $display("FAIL arst_gpio: got %h exp 0000", gpio_out); end
        bus_read(16'hF004, rd);
        tests++; if (rd !== 16'h0) begin fails++; $display("FAIL arst_timer: got %h exp 0000", rd); end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        bus_read(16'h0300, rd);
        tests++; if (rd !== 16'hCAFE) begin fails++; $display("FAIL arst_ram_kept: got %h exp cafe", rd); end
        bus_read(16'hF003, rd);
        tests++; if (rd !== 16'h0002) begin fails++; $display("FAIL arst_status: got %h exp 0002", rd); end
        exp_q.delete();
    endtask

    initial begin
        test_reset();
        test_ram();
        test_gpio();
        test_fifo();
        test_fifo_full_pop();
        test_timer();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit, tests=%0d", tests);
        $fatal(1);
    end

endmodule

// File: doc/rcpu_bus_slave.md
# rcpu_bus_slave

Memory-side responder for the RCPU memory port: services every CPU fetch, load and store on memAddr/memRead/memWrite/memRE/memWE. Provides word RAM below 0xF000 and a small MMIO page at 0xF000–0xF0FF: GPIO, a 4-deep byte TX FIFO with a valid/ready output, and a prescaled down-timer. Sits beside rcpu at the top level and is the only bus target.

## Interface
- M, 16, bus/word width.
- RAM_AW, 16, RAM index width. Array depth 2^RAM_AW; index = memAddr[RAM_AW-1:0].
- FIFO_DEPTH, 4, TX FIFO entries (power of two).
- TICK_DIV, 16, clk cycles per timer decrement (≥1).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- memAddr  in  M  CPU address.
- memWrite  in  M  CPU store data.
- memRE  in  1  read enable.
- memWE  in  1  write enable.
- memRead  out  M  read data; combinational from memAddr.
- gpio_out  out  16  output port register.
- gpio_in  in  16  asynchronous input pins.
- tx_data  out  8  FIFO head byte.
- tx_valid  out  1  FIFO non-empty.
- tx_ready  in  1  consumer accepts head when high with tx_valid.
- irq_timer  out  1  copy of the sticky timer-expired flag.

## Operation
- Address decode, as a decided map:
  - addr < 0xF000: RAM.
  - 0xF000 OUT: read/write gpio_out.
  - 0xF001 IN: read-only, 2-flop-synchronised gpio_in.
  - 0xF002 TXDATA: write pushes memWrite[7:0]; read returns 0.
  - 0xF003 STATUS: read bits {[15:8]=fifo count, [3]=overflow, [2]=expired, [1]=empty, [0]=full}. Write-1-to-clear bits 3 and 2.
  - 0xF004 TIMER: read current count; write loads the count and restarts the prescaler.
  - Other 0xF0xx/0xF1xx–0xFFFF: reads 0, writes ignored.
- Reads: memRead = decoded data when memRE=1, else 0. RAM read is asynchronous. Reads have no side effects, including STATUS and TXDATA.
- Writes: committed at the clk edge when memWE=1. If memRE and memWE are both high, the write still commits and memRead shows pre-edge data.
- FIFO:
  - A push when full is dropped and sets overflow, unless a pop occurs the same cycle, in which case it is accepted.
  - Pop occurs when tx_valid && tx_ready.
  - Push and pop in the same cycle leave count unchanged.
  - tx_data = 0 when empty.
- Timer:
  - The prescaler counts 0..TICK_DIV-1. On wrap, a nonzero count decrements.
  - A transition 1→0 sets expired, which is sticky. The count holds at 0.
  - Loading 0 never sets expired.
  - A CPU load takes priority over a same-cycle decrement.
  - A W1C of expired that coincides with a 1→0 event leaves expired set.

## Timing
- Read latency is 0 cycles; data is valid in the same cycle as the address.
- A write is visible to a read in the cycle after the write edge.
- Push at edge N: tx_valid is high from N and tx_data shows the byte if the FIFO was empty.
- A timer load of value K at edge N sets expired at edge N + K·TICK_DIV.
- GPIO input latency is 2 cycles.
- Reset values:
  - gpio_out = 0; tx_valid = 0; tx_data = 0; irq_timer = 0.
  - FIFO count/pointers = 0; overflow = 0; expired = 0; timer = 0; prescaler = 0; sync flops = 0.
  - memRead follows decode. RAM is not reset.
- Reset asserted mid-operation clears all of the above immediately. A push in flight is lost.

## Structure
- Shared include file "memMapConstants" holds the address constants (RAM_TOP = 16'hF000, OUT/IN/TXDATA/STATUS/TIMER addresses) and the STATUS bit positions. rcpu software tests use the same file.
- Sub-module tx_fifo (parameters FIFO_DEPTH, width 8): push/pop/full/empty/count, with the overflow rule inside it.
- The timer and decode stay in rcpu_bus_slave.

## Test plan
- Write 0x1234 to 0x0100, then read 0x0100 next cycle → memRead=0x1234. Read 0xF0FF → 0. Write to 0xF0FF → no state change.
- Write 0x00A5 to 0xF000 → gpio_out=0x00A5 after the edge. Set gpio_in=0xBEEF → reading 0xF001 gives 0xBEEF on the 3rd cycle.
- tx_ready=0; push 0x11, 0x22, 0x33, 0x44, 0x55:
  - STATUS reads count=4, full=1, overflow=1.
  - Raise tx_ready → tx_data pops 0x11, 0x22, 0x33, 0x44, then tx_valid=0.
  - Write 0x0008 to STATUS → overflow cleared.
- FIFO full with tx_ready=1, push 0x66 → accepted with no overflow; count stays 4.
- TICK_DIV=16; write 3 to 0xF004 → expired and irq_timer high exactly 48 cycles later; count holds 0. W1C 0x0004 clears it. Loading 0 never sets it.
- Drop rst low mid-count with FIFO holding 2 entries → tx_valid=0, gpio_out=0, timer=0 asynchronously. RAM contents are preserved.
